input_buffer_b4_ctrl: RTL and testbench

Sequencer for the 32-bank input buffer (32 single-port RAMs, 32-bit words, 7 rows each, 1-cycle registered read). Fills the banks from a valid/ready word stream, then replays the stored rows to the PE array one full row (all banks, same address) per issue, optionally for several passes. Sits between the input DMA stream and the buffer's per-bank DIN/ADDR/WEA/ENA pins. Top level fans the broadcast address and data out to all banks.

---
 rtl/input_buffer_b4_ctrl.sv | 170 +++++++++++++++++
 tb/tb_input_buffer_b4_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_buffer_b4_ctrl.sv
// Fill/replay sequencer for the banked input buffer: bank-major fill from a
// valid/ready stream, then full-row replays to the PE array over one or more passes.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | waiting for start
// S_FILL  | accepting stream words into the banks
// S_FULL  | all R rows written, waiting for rd_start
// S_READ  | issuing row reads while pe_ready is high
// S_DRAIN | last read issued, waiting for its row_valid
module input_buffer_b4_ctrl #(
    parameter int BANKS = 32,
    parameter int DEPTH = 7,
    parameter int AW    = 3,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW-1:0]    cfg_rows,
    input  logic [3:0]       cfg_passes,
    input  logic             soft_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic             rd_start,
    input  logic             pe_ready,
    output logic [DW-1:0]    buf_din,
    output logic [AW-1:0]    buf_addr,
    output logic [BANKS-1:0] buf_we,
    output logic [BANKS-1:0] buf_en,
    output logic             row_valid,
    output logic [AW-1:0]    row_idx,
    output logic [3:0]       pass_idx,
    output logic             full,
    output logic             busy,
    output logic             done
);
    localparam int BW  = $clog2(BANKS);
    localparam int WCW = BW + AW;
    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_FULL, S_READ, S_DRAIN} state_t;

    state_t            state;
    logic [WCW-1:0]    word_cnt;
    logic [AW-1:0]     rows_m1;
    logic [3:0]        passes_m1;
    logic [AW-1:0]     row;
    logic [3:0]        pass;
    logic              rd_vld_p1;
    logic [AW-1:0]     row_p1;
    logic [3:0]        pass_p1;
    logic              rows_over;
    logic [AW-1:0]     rows_clamped;
    logic [BW-1:0]     word_bank;
    logic [AW-1:0]     word_row;
    logic              last_word;

    // The upper clamp only exists when the address width can express rows past DEPTH.
    if (((1 << AW) - 1) > DEPTH) begin : g_clamp
        assign rows_over = (cfg_rows > DEPTH_A);
    end else begin : g_noclamp
        assign rows_over = 1'b0;
    end

    assign rows_clamped = ((cfg_rows == '0) || rows_over) ? DEPTH_A : cfg_rows;
    assign word_bank    = word_cnt[BW-1:0];
    assign word_row     = word_cnt[WCW-1:BW];
    assign last_word    = (word_row == rows_m1) && (&word_bank);

    assign in_ready = (state == S_FILL);
    assign full     = (state == S_FULL);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            word_cnt  <= '0;
            rows_m1   <= '0;
            passes_m1 <= '0;
            row       <= '0;
            pass      <= '0;
            rd_vld_p1 <= 1'b0;
            row_p1    <= '0;
            pass_p1   <= '0;
            buf_din   <= '0;
            buf_addr  <= '0;
            buf_we    <= '0;
            buf_en    <= '0;
            row_valid <= 1'b0;
            row_idx   <= '0;
            pass_idx  <= '0;
            done      <= 1'b0;
        end else begin
            buf_we    <= '0;
            buf_en    <= '0;
            done      <= 1'b0;
            rd_vld_p1 <= 1'b0;
            row_valid <= rd_vld_p1;
            if (rd_vld_p1) begin
                row_idx  <= row_p1;
                pass_idx <= pass_p1;
            end
            if (soft_clr) begin
                // Dropping rd_vld_p1 and row_valid kills reads already in flight.
                state     <= S_IDLE;
                word_cnt  <= '0;
                row       <= '0;
                pass      <= '0;
                row_valid <= 1'b0;
                row_idx   <= '0;
                pass_idx  <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            rows_m1   <= rows_clamped - 1'b1;
                            passes_m1 <= (cfg_passes == 4'd0) ? 4'd0 : cfg_passes - 4'd1;
                            word_cnt  <= '0;
                            state     <= S_FILL;
                        end
                    end
                    S_FILL: begin
                        if (in_valid) begin
                            buf_din  <= in_data;
                            buf_addr <= word_row;
                            buf_we   <= {{(BANKS-1){1'b0}}, 1'b1} << word_bank;
                            buf_en   <= {{(BANKS-1){1'b0}}, 1'b1} << word_bank;
                            word_cnt <= word_cnt + WCW'(1);
                            if (last_word) state <= S_FULL;
                        end
                    end
                    S_FULL: begin
                        if (rd_start) begin
                            row   <= '0;
                            pass  <= '0;
                            state <= S_READ;
                        end
                    end
                    S_READ: begin
                        if (pe_ready) begin
                            buf_en    <= '1;
                            buf_addr  <= row;
                            rd_vld_p1 <= 1'b1;
                            row_p1    <= row;
                            pass_p1   <= pass;
                            if (row == rows_m1) begin
                                row <= '0;
                                if (pass == passes_m1) state <= S_DRAIN;
                                else pass <= pass + 4'd1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (row_valid && !rd_vld_p1) begin
                            done  <= 1'b1;
                            row   <= '0;
                            pass  <= '0;
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_input_buffer_b4_ctrl.sv
// Bench for input_buffer_b4_ctrl: table of fill/replay configurations with random
// data, gaps and pe_ready, checked against a bank RAM model and a row-sequence model.
module tb_input_buffer_b4_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, soft_clr, in_valid, rd_start, pe_ready;
    logic [2:0]  cfg_rows;
    logic [3:0]  cfg_passes;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] buf_din;
    logic [2:0]  buf_addr;
    logic [31:0] buf_we, buf_en;
    logic        row_valid;
    logic [2:0]  row_idx;
    logic [3:0]  pass_idx;
    logic        full, busy, done;

    int total = 0;
    int bad   = 0;

    logic [31:0] ram [32][8];
    logic [31:0] dout [32];
    logic [31:0] exp_mem [32][8];

    typedef struct {
        logic [2:0] rows;
        logic [3:0] passes;
        int max_gap;
        int pe_mode;
        int exp_words;
        int exp_r;
        int exp_p;
    } vec_t;
    vec_t vecs[6];

    input_buffer_b4_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows),
        .cfg_passes(cfg_passes), .soft_clr(soft_clr), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .rd_start(rd_start),
        .pe_ready(pe_ready), .buf_din(buf_din), .buf_addr(buf_addr),
        .buf_we(buf_we), .buf_en(buf_en), .row_valid(row_valid),
        .row_idx(row_idx), .pass_idx(pass_idx), .full(full), .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // Single-port banks with registered read, driven by the DUT pins.
    always @(posedge clk) begin
        for (int b = 0; b < 32; b++) begin
            if (buf_en[b]) begin
                if (buf_we[b]) ram[b][buf_addr] <= buf_din;
                else dout[b] <= ram[b][buf_addr];
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_fill(input logic [2:0] rows, input logic [3:0] passes, input int words,
                           input int exp_r, input int max_gap, input bit seq_data);
        logic [31:0] d;
        cfg_rows   = rows;
        cfg_passes = passes;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        cfg_rows   = 3'($urandom);
        cfg_passes = 4'($urandom);
        for (int k = 0; k < words; k++) begin
            int gap;
            gap = $urandom_range(0, max_gap);
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                start    = ($urandom_range(0, 3) == 0);
                chk("fill_ready_gap", 64'(in_ready), 64'(1));
                tick();
                start = 1'b0;
            end
            d = seq_data ? 32'(k) : $urandom;
            exp_mem[k % 32][k / 32] = d;
            in_valid = 1'b1;
            in_data  = d;
            chk("fill_ready", 64'(in_ready), 64'(1));
            tick();
        end
        in_valid = 1'b0;
        chk("fill_ready_drop", 64'(in_ready), 64'(0));
        chk("full_rise", 64'(full), 64'(1));
        chk("busy_full", 64'(busy), 64'(1));
        tick();
        for (int a = 0; a < exp_r; a++)
            for (int b = 0; b < 32; b++)
                chk("ram_content", 64'(ram[b][a]), 64'(exp_mem[b][a]));
        chk("full_hold", 64'(full), 64'(1));
    endtask

    task automatic do_replay(input int r, input int p, input int pe_mode);
        int iss[$];
        int issued, rvn, last, fb, n_tot;
        bit finished, exp_en, exp_rv, exp_done, pe;
        n_tot = r * p;
        issued = 0; rvn = 0; last = -100; finished = 0;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < 3000 && !finished; i++) begin
            exp_en = (iss.size() > 0) && (iss[iss.size()-1] == i - 1);
            chk("rd_en", 64'(buf_en), exp_en ? 64'hffff_ffff : 64'(0));
            chk("rd_we", 64'(buf_we), 64'(0));
            if (exp_en) chk("rd_addr", 64'(buf_addr), 64'((iss.size() - 1) % r));
            exp_rv = (rvn < iss.size()) && (iss[rvn] + 2 == i);
            chk("row_valid", 64'(row_valid), 64'(exp_rv));
            if (exp_rv) begin
                chk("row_idx", 64'(row_idx), 64'(rvn % r));
                chk("pass_idx", 64'(pass_idx), 64'(rvn / r));
                fb = 0;
                for (int b = 31; b >= 0; b--)
                    if (dout[b] !== exp_mem[b][rvn % r]) fb = b;
                chk("row_data", 64'(dout[fb]), 64'(exp_mem[fb][rvn % r]));
                rvn++;
            end
            exp_done = (issued == n_tot) && (i == last + 3);
            chk("done", 64'(done), 64'(exp_done));
            chk("busy_read", 64'(busy), 64'(!exp_done));
            if (exp_done) finished = 1;
            case (pe_mode)
                0:       pe = 1'b1;
                1:       pe = (i % 2 == 0);
                default: pe = 1'($urandom_range(0, 1));
            endcase
            pe_ready = pe;
            if (pe && issued < n_tot) begin
                iss.push_back(i);
                issued++;
                if (issued == n_tot) last = i;
            end
            start    = (issued == n_tot) && (i == last + 2);
            cfg_rows = 3'd1;
            tick();
        end
        start    = 1'b0;
        pe_ready = 1'b0;
        if (!finished) begin
            total++;
            bad++;
            $display("FAIL replay_timeout: got no done expected done after %0d rows", n_tot);
        end
        chk("idle_after_done", 64'(busy), 64'(0));
        chk("done_pulse", 64'(done), 64'(0));
    endtask

    initial begin
        vecs[0] = '{3'd7, 4'd2,  0, 0, 224, 7, 2};
        vecs[1] = '{3'd7, 4'd1,  0, 1, 224, 7, 1};
        vecs[2] = '{3'd0, 4'd0,  3, 2, 224, 7, 1};
        vecs[3] = '{3'd3, 4'd1,  3, 2,  96, 3, 1};
        vecs[4] = '{3'd1, 4'd3,  1, 0,  32, 1, 3};
        vecs[5] = '{3'd5, 4'd15, 2, 2, 160, 5, 15};

        rst_n = 1'b0;
        start = 1'b0; soft_clr = 1'b0; in_valid = 1'b0; rd_start = 1'b0;
        pe_ready = 1'b0; cfg_rows = '0; cfg_passes = '0; in_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_buf_din", 64'(buf_din), 64'(0));
        chk("rst_buf_addr", 64'(buf_addr), 64'(0));
        chk("rst_buf_we", 64'(buf_we), 64'(0));
        chk("rst_buf_en", 64'(buf_en), 64'(0));
        chk("rst_row_valid", 64'(row_valid), 64'(0));
        chk("rst_row_idx", 64'(row_idx), 64'(0));
        chk("rst_pass_idx", 64'(pass_idx), 64'(0));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));

        // rd_start outside FULL must not leave IDLE.
        rd_start = 1'b1; pe_ready = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        chk("rd_start_idle_busy", 64'(busy), 64'(0));
        chk("rd_start_idle_en", 64'(buf_en), 64'(0));
        pe_ready = 1'b0;

        for (int v = 0; v < 6; v++) begin
            do_fill(vecs[v].rows, vecs[v].passes, vecs[v].exp_words, vecs[v].exp_r,
                    vecs[v].max_gap, (v == 0));
            do_replay(vecs[v].exp_r, vecs[v].exp_p, vecs[v].pe_mode);
        end

        // soft_clr after three issues in READ.
        do_fill(3'd7, 4'd1, 224, 7, 0, 1'b0);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        pe_ready = 1'b1;
        repeat (3) tick();
        chk("pre_clr_row_valid", 64'(row_valid), 64'(1));
        chk("pre_clr_row_idx", 64'(row_idx), 64'(1));
        soft_clr = 1'b1;
        tick();
        soft_clr = 1'b0;
        chk("clr_buf_en", 64'(buf_en), 64'(0));
        chk("clr_row_valid", 64'(row_valid), 64'(0));
        chk("clr_busy", 64'(busy), 64'(0));
        chk("clr_full", 64'(full), 64'(0));
        for (int i = 0; i < 8; i++) begin
            chk("clr_quiet_rv", 64'(row_valid), 64'(0));
            chk("clr_quiet_done", 64'(done), 64'(0));
            chk("clr_quiet_en", 64'(buf_en), 64'(0));
            chk("clr_quiet_busy", 64'(busy), 64'(0));
            tick();
        end
        pe_ready = 1'b0;
        do_fill(3'd3, 4'd1, 96, 3, 2, 1'b0);
        do_replay(3, 1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
